banco_registros_sb: RTL
=======================

Name: banco_registros_sb

Overview:
- Parametrised successor to the RV32I register bank: XLEN-wide, 2^AW entries, two asynchronous read ports and one synchronous write port.
- Same-cycle write-to-read bypass; register 0 is hardwired to zero.
- Per-register busy scoreboard: decode marks a destination pending at issue, writeback clears it.
- Sits between decode (read_r1/read_r2, issue) and writeback (RegWriteEn/rd/data) in the pipelined core.

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; NREGS = 2**AW entries.
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes/issues; 0 = entry 0 is ordinary.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- RegWriteEn  in  1  writeback enable.
- rd  in  AW  writeback destination.
- data  in  XLEN  writeback data.
- read_r1  in  AW  read address, port 1.
- read_r2  in  AW  read address, port 2.
- data_r1  out  XLEN  read data, port 1.
- data_r2  out  XLEN  read data, port 2.
- busy_r1  out  1  operand 1 still pending (consumer must stall).
- busy_r2  out  1  operand 2 still pending.
- issue_en  in  1  decode requests to mark issue_rd pending.
- issue_rd  in  AW  destination being issued.
- issue_ok  out  1  issue accepted this cycle.

Behaviour:
- Reset: when rst=1 at a rising edge, all NREGS entries become 0 and all busy bits become 0. rst dominates RegWriteEn and issue_en in the same cycle.
  - Outputs during/after reset: data_rN=0; busy_rN=0; issue_ok=0 while rst=1.
- Write:
  - Condition: rising edge with RegWriteEn=1, rst=0, and not (ZERO_REG and rd==0).
  - Effect: reg[rd] <= data.
  - Writes to entry 0 with ZERO_REG=1 are discarded.
- Read (combinational, zero latency):
  - data_rN = 0 if ZERO_REG and read_rN==0.
  - Otherwise data_rN = data if RegWriteEn and rd==read_rN (bypass).
  - Otherwise data_rN = reg[read_rN].
- Scoreboard, busy[i] next state:
  - Clear term: RegWriteEn and rd==i.
  - Set term: issue accepted with issue_rd==i.
  - If both occur in the same cycle on the same i, set wins: busy stays 1 for the new producer.
  - busy[0] is permanently 0 when ZERO_REG=1.
- busy_rN (combinational) = busy[read_rN] and not (RegWriteEn and rd==read_rN). A same-cycle writeback clears the hazard because the data is bypassed.
- Issue handshake (combinational):
  - issue_ok = issue_en and not rst and not (busy[issue_rd] and not (RegWriteEn and rd==issue_rd)).
  - Issue to a register already pending with no writeback this cycle is rejected (WAW); decode holds issue_en and retries.
  - issue_en with issue_rd==0 and ZERO_REG=1: issue_ok=1, no state change.
  - issue_ok has no effect when issue_en=0.
- Writeback to a non-busy register is legal: data is written, busy stays 0.
- No X propagation: every entry is defined after the first reset.
- No other latency: one-cycle write, zero-cycle read/busy/issue_ok.

Test Plan:
- Reset then write: rst=1 for 1 cycle; write 45 to x3, then 8 to x2; read_r1=3, read_r2=2 -> data_r1=45, data_r2=8. Read x1 -> 0. Write x1 with RegWriteEn=0 -> x1 stays 0.
- Zero register: RegWriteEn=1, rd=0, data=0xDEADBEEF; read_r1=0 -> data_r1=0. issue_en, issue_rd=0 -> issue_ok=1, busy_r1=0.
- Bypass: RegWriteEn=1, rd=7, data=0x12345678, read_r2=7 in the same cycle -> data_r2=0x12345678 before the edge; reg[7] holds it after the edge.
- Scoreboard: issue x5 (issue_ok=1); next cycle read_r1=5 -> busy_r1=1. Second issue to x5 -> issue_ok=0. Writeback x5=99 with read_r1=5 -> busy_r1=0, data_r1=99 that cycle. busy[5]=0 afterwards.
- Simultaneous set/clear: busy[4]=1; same cycle RegWriteEn rd=4 data=10 and issue_en issue_rd=4 -> issue_ok=1. After the edge busy_r1(read 4)=1 and reg[4]=10.
- Reset mid-operation: busy[6]=1, reg[6]=3; assert rst with RegWriteEn rd=6 data=77 and issue_en rd=9 -> after the edge reg[6]=0, busy[6]=0, busy[9]=0, issue_ok=0 during rst. Repeat with XLEN=16, AW=3: write 0xFFFF to x7, read back 0xFFFF.

Source files
------------

// File: rtl/banco_registros_sb_if.sv
// Register bank bus: writeback port, two decode read ports with busy
// flags, and the decode issue handshake that marks destinations pending.
interface banco_registros_sb_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    // Writeback side
    logic            RegWriteEn;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;

    // Decode read side
    logic [AW-1:0]   read_r1;
    logic [AW-1:0]   read_r2;
    logic [XLEN-1:0] data_r1;
    logic [XLEN-1:0] data_r2;
    logic            busy_r1;
    logic            busy_r2;

    // Decode issue side
    logic            issue_en;
    logic [AW-1:0]   issue_rd;
    logic            issue_ok;

    // Pipeline (decode + writeback) drives requests, sees results
    modport master (
        output RegWriteEn, rd, data,
        output read_r1, read_r2,
        output issue_en, issue_rd,
        input  data_r1, data_r2, busy_r1, busy_r2, issue_ok
    );

    // Register bank
    modport slave (
        input  RegWriteEn, rd, data,
        input  read_r1, read_r2,
        input  issue_en, issue_rd,
        output data_r1, data_r2, busy_r1, busy_r2, issue_ok
    );
endinterface

// File: rtl/banco_registros_sb.sv
// Parametrised register bank with two async read ports, one sync write
// port, same-cycle write-to-read bypass and a per-register busy scoreboard.
module banco_registros_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    banco_registros_sb_if.slave  bus
);
    localparam int NREGS = 2 ** AW;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr_en;

    logic wb_hit_r1;
    logic wb_hit_r2;
    logic wb_hit_issue;
    logic zero_r1;
    logic zero_r2;
    logic zero_issue;
    logic zero_wr;
    logic issue_ok;

    // Address match / zero-register decode shared by read, busy and issue logic
    always_comb begin
        wb_hit_r1    = bus.RegWriteEn && (bus.rd == bus.read_r1);
        wb_hit_r2    = bus.RegWriteEn && (bus.rd == bus.read_r2);
        wb_hit_issue = bus.RegWriteEn && (bus.rd == bus.issue_rd);
        zero_r1      = ZERO_REG && (bus.read_r1 == '0);
        zero_r2      = ZERO_REG && (bus.read_r2 == '0);
        zero_issue   = ZERO_REG && (bus.issue_rd == '0);
        zero_wr      = ZERO_REG && (bus.rd == '0);
    end

    // Issue is refused only on a WAW: target pending and not retiring this cycle
    always_comb begin
        issue_ok = bus.issue_en && !rst && !(busy_q[bus.issue_rd] && !wb_hit_issue);
    end

    // Read ports: zero register, then bypass, then stored value; forced to 0 in reset
    always_comb begin
        if (rst || zero_r1) begin
            bus.data_r1 = '0;
        end else if (wb_hit_r1) begin
            bus.data_r1 = bus.data;
        end else begin
            bus.data_r1 = regs_q[bus.read_r1];
        end

        if (rst || zero_r2) begin
            bus.data_r2 = '0;
        end else if (wb_hit_r2) begin
            bus.data_r2 = bus.data;
        end else begin
            bus.data_r2 = regs_q[bus.read_r2];
        end
    end

    // Busy flags: a same-cycle writeback to the operand is bypassed, so no stall
    always_comb begin
        bus.busy_r1  = !rst && busy_q[bus.read_r1] && !wb_hit_r1;
        bus.busy_r2  = !rst && busy_q[bus.read_r2] && !wb_hit_r2;
        bus.issue_ok = issue_ok;
    end

    // Per-entry write enables and scoreboard next state (set beats clear)
    always_comb begin
        wr_en  = '0;
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.RegWriteEn && !zero_wr && (bus.rd == AW'(i))) begin
                wr_en[i]  = 1'b1;
                busy_d[i] = 1'b0;
            end
            if (issue_ok && !zero_issue && (bus.issue_rd == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // Storage and scoreboard update; reset clears every entry and busy bit
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en[i]) begin
                    regs_q[i] <= bus.data;
                end
            end
        end
    end
endmodule
